// File: rtl/xst_fifo.sv
// ----------------------------------------------------------------------------
// xst_fifo - frame-programmable synchronous serial transmitter with a transmit
// FIFO and a loop-capable receive shifter.
//
// Words written through txreg_we_i are queued in a DEPTH-entry FIFO. Each
// word is sent as one frame. When a frame loads, the block latches the frame
// length, the bit order and the baud divisor. Queued frames follow each other
// with no idle gap. A write into an empty FIFO while idle bypasses the queue
// and starts shifting on the next edge. The receive side samples rxd_i once
// per bit cell, in the middle of the cell. At the end of the frame it
// presents the assembled word.
//
// Ports
//   clk_i        sole clock, rising edge
//   reset_i      synchronous, active-high reset (flushes FIFO, drops frame)
//   dat_i        word to queue; bit 0 is sent first when LSB-first
//   txreg_we_i   write strobe, queues dat_i (dropped and ovf_o set if full)
//   bits_i       bits per frame, clamped to 1..WIDTH, latched at load
//   txbaud_i     bit cell length minus 1, latched at load
//   msb_first_i  bit order, latched at load
//   rxd_i        serial receive input
//   txd_o        serial data out, 1 when idle
//   txc_o        bit clock, high in the first half of each bit cell
//   idle_o       1 when no frame is shifting
//   brg_o        current baud down-counter
//   full_o       FIFO full
//   level_o      FIFO occupancy
//   ovf_o        sticky, a write was dropped
//   rxdat_o      last received frame, right-justified, upper bits 0
//   rxvalid_o    one-cycle pulse when rxdat_o updates
// ----------------------------------------------------------------------------
module xst_fifo #(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 4,
    parameter int BRG_W  = 16,
    parameter int BITS_W = 7,
    parameter int LVL_W  = 3
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [WIDTH-1:0]  dat_i,
    input  logic              txreg_we_i,
    input  logic [BITS_W-1:0] bits_i,
    input  logic [BRG_W-1:0]  txbaud_i,
    input  logic              msb_first_i,
    input  logic              rxd_i,
    output logic              txd_o,
    output logic              txc_o,
    output logic              idle_o,
    output logic [BRG_W-1:0]  brg_o,
    output logic              full_o,
    output logic [LVL_W-1:0]  level_o,
    output logic              ovf_o,
    output logic [WIDTH-1:0]  rxdat_o,
    output logic              rxvalid_o
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [BITS_W-1:0] WIDTH_B = BITS_W'(WIDTH);
    localparam logic [LVL_W-1:0]  DEPTH_L = LVL_W'(DEPTH);

    // FIFO state
    logic [WIDTH-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [LVL_W-1:0] level_q;
    logic             ovf_q;

    // Transmit state. The frame word is held still and bit_idx walks across
    // it, so the receive side can use the same index to place each sample.
    logic [WIDTH-1:0] tx_word;
    logic [IDX_W-1:0] bit_idx;
    logic [IDX_W-1:0] nbits_m1;
    logic [BRG_W-1:0] baud_q;
    logic [BRG_W-1:0] brg_q;
    logic             msb_q;
    logic             idle_q;
    logic             txd_q;

    // Receive state
    logic [WIDTH-1:0] rx_q;
    logic [WIDTH-1:0] rx_next;
    logic [WIDTH-1:0] rxdat_q;
    logic             rxvalid_q;

    // Control
    logic             empty;
    logic             full;
    logic             push_ok;
    logic             last_bit;
    logic             term;
    logic             load;
    logic             pop;
    logic             fifo_wr;
    logic             sample;
    logic [WIDTH-1:0] load_word;
    logic [IDX_W-1:0] nbits_m1_new;
    logic [IDX_W-1:0] first_idx;
    logic [IDX_W-1:0] next_idx;

    assign empty    = (level_q == '0);
    assign full     = (level_q == DEPTH_L);
    assign push_ok  = txreg_we_i & ~full;
    assign last_bit = msb_q ? (bit_idx == '0) : (bit_idx == nbits_m1);
    // Terminal cycle: the last bit cell has run out.
    assign term     = ~idle_q & (brg_q == '0) & last_bit;
    assign load     = (idle_q | term) & (~empty | push_ok);
    assign pop      = load & ~empty;
    // A write into an empty FIFO that loads in the same cycle goes straight
    // to the shifter and never occupies an entry.
    assign fifo_wr  = push_ok & ~(load & empty);
    assign load_word = empty ? dat_i : fifo_mem[rd_ptr];
    assign first_idx = msb_first_i ? nbits_m1_new : '0;
    assign next_idx  = msb_q ? (bit_idx - IDX_W'(1)) : (bit_idx + IDX_W'(1));
    assign sample    = ~idle_q & (brg_q == (baud_q >> 1));

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path can leave it holding its old value and infer a latch.
    always_comb begin
        nbits_m1_new = '0;
        if (bits_i == '0) begin
            nbits_m1_new = '0;
        end else if (bits_i > WIDTH_B) begin
            nbits_m1_new = IDX_W'(WIDTH - 1);
        end else begin
            nbits_m1_new = IDX_W'(bits_i - BITS_W'(1));
        end
    end

    // Current receive word including this cycle's sample. The terminal cycle
    // can also be the sample cycle when baud is 0 or 1, so rxdat_o takes
    // this value rather than rx_q.
    always_comb begin
        rx_next = rx_q;
        if (sample) begin
            rx_next[bit_idx] = rxd_i;
        end
    end

    // NOTE: the storage array is left out of reset. Flushing is done by
    // clearing the pointers and the level, and the entries are never read
    // before they are written.
    always_ff @(posedge clk_i) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr] <= dat_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // block sees the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            // Gated on full alone: a pop in the same cycle does not save the word.
            if (txreg_we_i && full) begin
                ovf_q <= 1'b1;
            end
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({fifo_wr, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Transmit shifter and baud counter
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_word  <= '0;
            bit_idx  <= '0;
            nbits_m1 <= '0;
            baud_q   <= '0;
            brg_q    <= '0;
            msb_q    <= 1'b0;
            idle_q   <= 1'b1;
            txd_q    <= 1'b1;
        end else if (load) begin
            tx_word  <= load_word;
            nbits_m1 <= nbits_m1_new;
            baud_q   <= txbaud_i;
            msb_q    <= msb_first_i;
            brg_q    <= txbaud_i;
            bit_idx  <= first_idx;
            txd_q    <= load_word[first_idx];
            idle_q   <= 1'b0;
        end else if (!idle_q) begin
            if (brg_q != '0) begin
                brg_q <= brg_q - BRG_W'(1);
            end else if (!last_bit) begin
                brg_q   <= baud_q;
                bit_idx <= next_idx;
                txd_q   <= tx_word[next_idx];
            end else begin
                idle_q <= 1'b1;
                txd_q  <= 1'b1;
            end
        end
    end

    // Receive shifter. It is cleared on every load so bits at and above
    // nbits read as zero.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_q      <= '0;
            rxdat_q   <= '0;
            rxvalid_q <= 1'b0;
        end else begin
            rx_q      <= load ? '0 : rx_next;
            rxvalid_q <= term;
            if (term) begin
                rxdat_q <= rx_next;
            end
        end
    end

    assign txd_o     = txd_q;
    assign txc_o     = ~idle_q & (brg_q >= (baud_q >> 1));
    assign idle_o    = idle_q;
    assign brg_o     = brg_q;
    assign full_o    = full;
    assign level_o   = level_q;
    assign ovf_o     = ovf_q;
    assign rxdat_o   = rxdat_q;
    assign rxvalid_o = rxvalid_q;

endmodule

// File: tb/tb_xst_fifo.sv
// ----------------------------------------------------------------------------
// tb_xst_fifo - directed bench for xst_fifo with rxd_i looped back to txd_o.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// ----------------------------------------------------------------------------
module tb_xst_fifo;

    logic        clk;
    logic        reset;
    logic [63:0] dat;
    logic        we;
    logic [6:0]  bits;
    logic [15:0] baud;
    logic        msb;
    logic        rxd;
    logic        txd;
    logic        txc;
    logic        idle;
    logic [15:0] brg;
    logic        full;
    logic [2:0]  level;
    logic        ovf;
    logic [63:0] rxdat;
    logic        rxvalid;

    int n_tests;
    int n_fail;

    xst_fifo #(
        .WIDTH(64), .DEPTH(4), .BRG_W(16), .BITS_W(7), .LVL_W(3)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .dat_i       (dat),
        .txreg_we_i  (we),
        .bits_i      (bits),
        .txbaud_i    (baud),
        .msb_first_i (msb),
        .rxd_i       (rxd),
        .txd_o       (txd),
        .txc_o       (txc),
        .idle_o      (idle),
        .brg_o       (brg),
        .full_o      (full),
        .level_o     (level),
        .ovf_o       (ovf),
        .rxdat_o     (rxdat),
        .rxvalid_o   (rxvalid)
    );

    assign rxd = txd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] w;
    logic [63:0] rx_seen [8];
    int          rx_cyc  [8];
    int          pulses;
    int          idle_err;
    int          max_lvl;
    int          b;
    int          k;
    logic [63:0] ovf_words [6];
    logic [63:0] msb_vec [2];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        dat   = '0;
        we    = 1'b0;
        bits  = 7'd11;
        baud  = 16'd4;
        msb   = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // ---------------- reset state ----------------
        check("rst_txd",     {63'd0, txd},     64'd1);
        check("rst_txc",     {63'd0, txc},     64'd0);
        check("rst_idle",    {63'd0, idle},    64'd1);
        check("rst_brg",     {48'd0, brg},     64'd0);
        check("rst_full",    {63'd0, full},    64'd0);
        check("rst_level",   {61'd0, level},   64'd0);
        check("rst_ovf",     {63'd0, ovf},     64'd0);
        check("rst_rxdat",   rxdat,            64'd0);
        check("rst_rxvalid", {63'd0, rxvalid}, 64'd0);

        // ---------------- single frame 0x622, 11 bits, baud 4, LSB-first ----
        w   = 64'h622;
        dat = w;
        we  = 1'b1;
        tick();
        we  = 1'b0;
        // Changing the frame controls mid-frame must not affect this frame.
        bits = 7'd3;
        baud = 16'd7;
        msb  = 1'b1;
        for (int c = 0; c < 55; c++) begin
            b = c / 5;
            k = c % 5;
            check($sformatf("t1_txd_c%0d", c),  {63'd0, txd},  {63'd0, w[b]});
            check($sformatf("t1_brg_c%0d", c),  {48'd0, brg},  64'(4 - k));
            check($sformatf("t1_txc_c%0d", c),  {63'd0, txc},  ((4 - k) >= 2) ? 64'd1 : 64'd0);
            check($sformatf("t1_idle_c%0d", c), {63'd0, idle}, 64'd0);
            check($sformatf("t1_rxv_c%0d", c),  {63'd0, rxvalid}, 64'd0);
            tick();
        end
        check("t1_idle_end",  {63'd0, idle},    64'd1);
        check("t1_txd_end",   {63'd0, txd},     64'd1);
        check("t1_rxvalid",   {63'd0, rxvalid}, 64'd1);
        check("t1_rxdat",     rxdat,            64'h622);
        tick();
        check("t1_rxvalid_1cyc", {63'd0, rxvalid}, 64'd0);

        // ---------------- back-to-back: 0x622, 0x7FF, 0x401 ----------------
        bits = 7'd11;
        baud = 16'd4;
        msb  = 1'b0;
        dat  = 64'h622;
        we   = 1'b1;
        tick();                         // c = 0
        dat  = 64'h7FF;
        tick();                         // c = 1
        check("b2b_level_c1", {61'd0, level}, 64'd1);
        dat  = 64'h401;
        tick();                         // c = 2
        we   = 1'b0;
        check("b2b_level_c2", {61'd0, level}, 64'd2);
        pulses   = 0;
        idle_err = 0;
        max_lvl  = 0;
        for (int c = 2; c <= 165; c++) begin
            if (int'(level) > max_lvl) max_lvl = int'(level);
            if (rxvalid) begin
                if (pulses < 8) begin
                    rx_seen[pulses] = rxdat;
                    rx_cyc[pulses]  = c;
                end
                pulses++;
            end
            if (c < 165 && idle) idle_err++;
            if (c == 54) check("b2b_brg_c54", {48'd0, brg}, 64'd0);
            if (c == 55) begin
                check("b2b_f2_txd",   {63'd0, txd},   64'd1);
                check("b2b_f2_brg",   {48'd0, brg},   64'd4);
                check("b2b_f2_level", {61'd0, level}, 64'd1);
            end
            if (c == 110) begin
                check("b2b_f3_txd",   {63'd0, txd},   64'd1);
                check("b2b_f3_brg",   {48'd0, brg},   64'd4);
                check("b2b_f3_level", {61'd0, level}, 64'd0);
            end
            if (c < 165) tick();
        end
        check("b2b_idle_gap",  64'(idle_err), 64'd0);
        check("b2b_idle_end",  {63'd0, idle}, 64'd1);
        check("b2b_max_level", 64'(max_lvl),  64'd2);
        check("b2b_pulses",    64'(pulses),   64'd3);
        if (pulses == 3) begin
            check("b2b_rx0", rx_seen[0], 64'h622);
            check("b2b_rx1", rx_seen[1], 64'h7FF);
            check("b2b_rx2", rx_seen[2], 64'h401);
            check("b2b_rx0_cyc", 64'(rx_cyc[0]), 64'd55);
            check("b2b_rx1_cyc", 64'(rx_cyc[1]), 64'd110);
            check("b2b_rx2_cyc", 64'(rx_cyc[2]), 64'd165);
        end
        tick();

        // ---------------- overflow: in-flight frame plus 5 writes ----------
        ovf_words[0] = 64'h3;
        ovf_words[1] = 64'h5;
        ovf_words[2] = 64'hA;
        ovf_words[3] = 64'hC;
        ovf_words[4] = 64'h9;
        ovf_words[5] = 64'hF;
        bits = 7'd4;
        baud = 16'd1;
        msb  = 1'b0;
        dat  = ovf_words[0];
        we   = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) begin
            dat = ovf_words[i];
            tick();
        end
        check("ovf_full_4",  {63'd0, full},   64'd1);
        check("ovf_level_4", {61'd0, level},  64'd4);
        check("ovf_ovf_4",   {63'd0, ovf},    64'd0);
        dat = ovf_words[5];
        tick();
        we  = 1'b0;
        check("ovf_level_5", {61'd0, level},  64'd4);
        check("ovf_ovf_5",   {63'd0, ovf},    64'd1);
        pulses = 0;
        for (int n = 0; n < 200; n++) begin
            if (rxvalid) begin
                if (pulses < 8) rx_seen[pulses] = rxdat;
                pulses++;
            end
            if (idle && level == 3'd0) break;
            tick();
        end
        check("ovf_drained", {63'd0, idle}, 64'd1);
        check("ovf_frames",  64'(pulses),   64'd5);
        if (pulses == 5) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("ovf_rx%0d", i), rx_seen[i], ovf_words[i]);
            end
        end
        check("ovf_sticky", {63'd0, ovf},  64'd1);
        check("ovf_full_0", {63'd0, full}, 64'd0);
        tick();

        // ---------------- MSB-first, 8 bits, baud 1 ----------------
        msb_vec[0] = 64'h81;
        msb_vec[1] = 64'h0D;
        for (int v = 0; v < 2; v++) begin
            w    = msb_vec[v];
            bits = 7'd8;
            baud = 16'd1;
            msb  = 1'b1;
            dat  = w;
            we   = 1'b1;
            tick();
            we   = 1'b0;
            msb  = 1'b0;
            for (int c = 0; c < 16; c++) begin
                b = 7 - c / 2;
                check($sformatf("msb%0d_txd_c%0d", v, c), {63'd0, txd}, {63'd0, w[b]});
                check($sformatf("msb%0d_brg_c%0d", v, c), {48'd0, brg}, 64'(1 - c % 2));
                tick();
            end
            check($sformatf("msb%0d_idle", v),  {63'd0, idle},    64'd1);
            check($sformatf("msb%0d_rxv", v),   {63'd0, rxvalid}, 64'd1);
            check($sformatf("msb%0d_rxdat", v), rxdat,            w);
            tick();
        end

        // ---------------- bits_i = 0 acts as 1 bit; upper rx bits zeroed ---
        bits = 7'd0;
        baud = 16'd2;
        msb  = 1'b0;
        dat  = 64'h3;
        we   = 1'b1;
        tick();
        we   = 1'b0;
        check("b0_txd", {63'd0, txd}, 64'd1);
        check("b0_brg", {48'd0, brg}, 64'd2);
        tick();
        tick();
        check("b0_brg_end", {48'd0, brg}, 64'd0);
        tick();
        check("b0_idle",  {63'd0, idle},    64'd1);
        check("b0_rxv",   {63'd0, rxvalid}, 64'd1);
        check("b0_rxdat", rxdat,            64'd1);
        tick();

        // ---------------- bits_i above WIDTH clamps to 64; baud 0 --------
        w    = 64'hDEADBEEF01234567;
        bits = 7'd100;
        baud = 16'd0;
        msb  = 1'b0;
        dat  = w;
        we   = 1'b1;
        tick();
        we   = 1'b0;
        check("w64_txc", {63'd0, txc}, 64'd1);
        idle_err = 0;
        for (int c = 0; c < 64; c++) begin
            if (txd !== w[c] || brg !== 16'd0 || idle !== 1'b0) idle_err++;
            tick();
        end
        check("w64_bits", 64'(idle_err), 64'd0);
        check("w64_idle",  {63'd0, idle},    64'd1);
        check("w64_rxv",   {63'd0, rxvalid}, 64'd1);
        check("w64_rxdat", rxdat,            w);
        tick();

        // ---------------- reset mid-frame with 2 words queued -------------
        bits = 7'd11;
        baud = 16'd4;
        msb  = 1'b0;
        dat  = 64'h622;
        we   = 1'b1;
        tick();                         // c = 0
        dat  = 64'h7FF;
        tick();                         // c = 1
        dat  = 64'h401;
        tick();                         // c = 2
        we   = 1'b0;
        check("mr_level_2",  {61'd0, level}, 64'd2);
        check("mr_ovf_pre",  {63'd0, ovf},   64'd1);
        for (int c = 2; c < 20; c++) tick();
        check("mr_active_20", {63'd0, idle}, 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_txd",   {63'd0, txd},     64'd1);
        check("mr_idle",  {63'd0, idle},    64'd1);
        check("mr_level", {61'd0, level},   64'd0);
        check("mr_brg",   {48'd0, brg},     64'd0);
        check("mr_ovf",   {63'd0, ovf},     64'd0);
        check("mr_full",  {63'd0, full},    64'd0);
        check("mr_rxdat", rxdat,            64'd0);
        pulses   = 0;
        idle_err = 0;
        for (int n = 0; n < 150; n++) begin
            if (rxvalid) pulses++;
            if (!idle) idle_err++;
            tick();
        end
        check("mr_no_rxvalid", 64'(pulses),   64'd0);
        check("mr_stays_idle", 64'(idle_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
